// File: rtl/rv32i_pkg.sv
// ============================================================================
// Package : rv32i_pkg
// Brief   : RV32I format codes, opcodes and the decoded bundle type.
//           IMM_DECODE_ILLEGAL_EN adds the illegal flag to the bundle.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package rv32i_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    fmt_e        fmt;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
`ifdef IMM_DECODE_ILLEGAL_EN
    logic        illegal;
`endif
  } decoded_t;

endpackage

`default_nettype wire

// File: rtl/imm_assemble.sv
// ============================================================================
// Module : imm_assemble
// Brief  : Combinational RV32I format classifier and immediate assembler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_assemble
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output fmt_e        fmt,
  output logic [31:0] imm
);

  always_comb begin
    fmt = FMT_NONE;
    unique case (instr[6:0])
      OP_LUI, OP_AUIPC:                                  fmt = FMT_U;
      OP_JAL:                                            fmt = FMT_J;
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM:     fmt = FMT_I;
      OP_STORE:                                          fmt = FMT_S;
      OP_BRANCH:                                         fmt = FMT_B;
      OP_REG:                                            fmt = FMT_R;
      default:                                           fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    imm = 32'd0;
    case (fmt)
      FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm = {instr[31:12], 12'd0};
      FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_decode_stage.sv
// ============================================================================
// Module : imm_decode_stage
// Brief  : Registered RV32I decode stage with output + skid buffer so that
//          in_ready is a register. Option macro: IMM_DECODE_ILLEGAL_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_decode_stage
  import rv32i_pkg::*;
(
  input  logic        clock,
  input  logic        nReset,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  fmt_out,
  output logic [31:0] imm_out,
  output logic [6:0]  opcode_out,
  output logic [4:0]  rd_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [2:0]  funct3_out,
`ifdef IMM_DECODE_ILLEGAL_EN
  output logic        illegal_out,
`endif
  output logic        funct7b5_out
);

  fmt_e        w_fmt;
  logic [31:0] w_imm;
  decoded_t    w_dec;
  decoded_t    r_out;
  decoded_t    r_skid;
  logic        r_out_valid;
  logic        r_skid_valid;
  logic        w_xfer;
  logic        w_out_load;

  imm_assemble u_imm_assemble (
    .instr (instr_in),
    .fmt   (w_fmt),
    .imm   (w_imm)
  );

  always_comb begin
    w_dec          = '0;
    w_dec.fmt      = w_fmt;
    w_dec.imm      = w_imm;
    w_dec.opcode   = instr_in[6:0];
    w_dec.rd       = instr_in[11:7];
    w_dec.rs1      = instr_in[19:15];
    w_dec.rs2      = instr_in[24:20];
    w_dec.funct3   = instr_in[14:12];
    w_dec.funct7b5 = instr_in[30];
`ifdef IMM_DECODE_ILLEGAL_EN
    w_dec.illegal  = (w_fmt == FMT_NONE) || (instr_in[1:0] != 2'b11);
`endif
  end

  assign in_ready   = !r_skid_valid;
  assign w_xfer     = in_valid && !r_skid_valid;
  assign w_out_load = !r_out_valid || out_ready;

  // in_ready is low whenever the skid holds data, so a skid drain never
  // coincides with an accepted input.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_load) begin
      r_out_valid  <= r_skid_valid || w_xfer;
      r_skid_valid <= 1'b0;
      if (r_skid_valid) begin
        r_out <= r_skid;
      end else if (w_xfer) begin
        r_out <= w_dec;
      end
    end else if (w_xfer) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign out_valid    = r_out_valid;
  assign fmt_out      = r_out.fmt;
  assign imm_out      = r_out.imm;
  assign opcode_out   = r_out.opcode;
  assign rd_out       = r_out.rd;
  assign rs1_out      = r_out.rs1;
  assign rs2_out      = r_out.rs2;
  assign funct3_out   = r_out.funct3;
  assign funct7b5_out = r_out.funct7b5;
`ifdef IMM_DECODE_ILLEGAL_EN
  assign illegal_out  = r_out.illegal;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
// ============================================================================
// Module : tb_imm_decode_stage
// Brief  : Directed self-checking bench for imm_decode_stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imm_decode_stage;

  logic        clock;
  logic        nReset;
  logic        flush;
  logic [31:0] instr_in;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fmt_out;
  logic [31:0] imm_out;
  logic [6:0]  opcode_out;
  logic [4:0]  rd_out;
  logic [4:0]  rs1_out;
  logic [4:0]  rs2_out;
  logic [2:0]  funct3_out;
  logic        funct7b5_out;
`ifdef IMM_DECODE_ILLEGAL_EN
  logic        illegal_out;
`endif

  int total = 0;
  int bad   = 0;

  imm_decode_stage dut (
    .clock        (clock),
    .nReset       (nReset),
    .flush        (flush),
    .instr_in     (instr_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fmt_out      (fmt_out),
    .imm_out      (imm_out),
    .opcode_out   (opcode_out),
    .rd_out       (rd_out),
    .rs1_out      (rs1_out),
    .rs2_out      (rs2_out),
    .funct3_out   (funct3_out),
`ifdef IMM_DECODE_ILLEGAL_EN
    .illegal_out  (illegal_out),
`endif
    .funct7b5_out (funct7b5_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    nReset = 1'b0; flush = 1'b0; instr_in = 32'd0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if ({fmt_out, imm_out, opcode_out, rd_out, rs1_out, rs2_out, funct3_out, funct7b5_out} !== 61'd0) begin
      bad++; $display("FAIL reset_bundle fmt=%0d imm=%h op=%h rd=%0d got nonzero want 0", fmt_out, imm_out, opcode_out, rd_out);
    end
    nReset = 1'b1;
    tick();
  endtask

  task automatic test_formats();
    logic [31:0] v_instr [10];
    logic [2:0]  v_fmt   [10];
    logic [31:0] v_imm   [10];
    logic [4:0]  v_rd    [10];
    logic [4:0]  v_rs1   [10];
    logic [4:0]  v_rs2   [10];
    logic [2:0]  v_f3    [10];
    logic        v_f7    [10];
    v_instr = '{32'hFFF00093, 32'hFE21AE23, 32'hFE000CE3, 32'h123452B7, 32'h0010006F,
                32'h002081B3, 32'h00000000, 32'hFFC08067, 32'h0040A103, 32'h00001517};
    v_fmt   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd6, 3'd1, 3'd1, 3'd4};
    v_imm   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800,
                32'h0, 32'h0, 32'hFFFFFFFC, 32'h00000004, 32'h00001000};
    v_rd    = '{5'd1, 5'd28, 5'd25, 5'd5, 5'd0, 5'd3, 5'd0, 5'd0, 5'd2, 5'd10};
    v_rs1   = '{5'd0, 5'd3, 5'd0, 5'd8, 5'd0, 5'd1, 5'd0, 5'd1, 5'd1, 5'd0};
    v_rs2   = '{5'd31, 5'd2, 5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd28, 5'd4, 5'd0};
    v_f3    = '{3'd0, 3'd2, 3'd0, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd1};
    v_f7    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      instr_in = v_instr[i];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      instr_in = 32'hDEADBEEF;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fmt_vec%0d_valid got=%0b want=1", i, out_valid); end
      total++; if (fmt_out !== v_fmt[i]) begin bad++; $display("FAIL fmt_vec%0d_fmt got=%0d want=%0d", i, fmt_out, v_fmt[i]); end
      total++; if (imm_out !== v_imm[i]) begin bad++; $display("FAIL fmt_vec%0d_imm got=%h want=%h", i, imm_out, v_imm[i]); end
      total++; if (opcode_out !== v_instr[i][6:0]) begin bad++; $display("FAIL fmt_vec%0d_opcode got=%h want=%h", i, opcode_out, v_instr[i][6:0]); end
      total++; if ({rd_out, rs1_out, rs2_out} !== {v_rd[i], v_rs1[i], v_rs2[i]}) begin
        bad++; $display("FAIL fmt_vec%0d_regs got=%0d,%0d,%0d want=%0d,%0d,%0d", i, rd_out, rs1_out, rs2_out, v_rd[i], v_rs1[i], v_rs2[i]);
      end
      total++; if ({funct3_out, funct7b5_out} !== {v_f3[i], v_f7[i]}) begin
        bad++; $display("FAIL fmt_vec%0d_funct got=%0d,%0b want=%0d,%0b", i, funct3_out, funct7b5_out, v_f3[i], v_f7[i]);
      end
`ifdef IMM_DECODE_ILLEGAL_EN
      total++; if (illegal_out !== (i == 6)) begin bad++; $display("FAIL fmt_vec%0d_illegal got=%0b want=%0b", i, illegal_out, (i == 6)); end
`endif
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fmt_vec%0d_drain got=%0b want=0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s_instr [4];
    logic [31:0] s_imm   [4];
    s_instr = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093};
    s_imm   = '{32'd1, 32'd2, 32'd3, 32'd4};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr_in = s_instr[i];
      in_valid = 1'b1;
      tick();
      total++; if (out_valid !== 1'b1 || imm_out !== s_imm[i]) begin
        bad++; $display("FAIL b2b_%0d got valid=%0b imm=%h want valid=1 imm=%h", i, out_valid, imm_out, s_imm[i]);
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d got=%0b want=1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail got=%0b want=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    instr_in = 32'h00A00093; in_valid = 1'b1;       // A: imm 10
    tick();
    total++; if (out_valid !== 1'b1 || imm_out !== 32'd10 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_a got valid=%0b imm=%h rdy=%0b want 1,a,1", out_valid, imm_out, in_ready);
    end
    instr_in = 32'h00B00093;                        // B: imm 11
    tick();
    total++; if (imm_out !== 32'd10 || in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_b got imm=%h rdy=%0b want imm=a rdy=0", imm_out, in_ready);
    end
    instr_in = 32'h00C00093;                        // C: imm 12
    tick();
    total++; if (out_valid !== 1'b1 || imm_out !== 32'd10 || rd_out !== 5'd1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_stable got valid=%0b imm=%h rdy=%0b want 1,a,0", out_valid, imm_out, in_ready);
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || imm_out !== 32'd11 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_rel_b got valid=%0b imm=%h rdy=%0b want 1,b,1", out_valid, imm_out, in_ready);
    end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || imm_out !== 32'd12) begin
      bad++; $display("FAIL bp_rel_c got valid=%0b imm=%h want 1,c", out_valid, imm_out);
    end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_nodup got=%0b want=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    instr_in = 32'h00A00093; in_valid = 1'b1;
    tick();
    instr_in = 32'h00B00093;
    tick();
    instr_in = 32'h00C00093; flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush got valid=%0b rdy=%0b want 0,1", out_valid, in_ready);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_after got=%0b want=0", out_valid); end
    // Flush coinciding with a transfer into an empty stage drops the word.
    instr_in = 32'h00D00093; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_xfer got=%0b want=0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    instr_in = 32'hFFF00093; in_valid = 1'b1;
    tick();
    instr_in = 32'h123452B7;
    tick();
    in_valid = 1'b0;
    #2 nReset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || imm_out !== 32'd0 || rd_out !== 5'd0) begin
      bad++; $display("FAIL async_reset got valid=%0b rdy=%0b imm=%h want 0,1,0", out_valid, in_ready, imm_out);
    end
    tick();
    nReset = 1'b1;
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_residual got=%0b want=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
